clk_div_gen: RTL and testbench

Runtime-programmable integer clock divider. It supports both odd and even divisors with exactly 50 % duty cycle, and emits a one-cycle `i_clk`-domain tick per output period. Divisor changes are applied only at period boundaries, so `o_clk` never glitches. It sits between the system clock and the UART baud/sample logic: `o_tick` drives clock enables, and `o_clk` is for legacy divided-clock consumers.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_negreg.sv | 10 +
 rtl/clk_div_gen.sv | 67 ++++++
 tb/tb_clk_div_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider
`timescale 1ns/1ps
package clk_div_pkg;
   typedef logic [31:0] div_word_t;
   localparam div_word_t DIV_MIN = 32'd2;
   function automatic logic [32:0] half_hi(input div_word_t n);
      return ({1'b0, n} + 33'd1) >> 1;
   endfunction
   function automatic div_word_t clamp_div(input div_word_t n);
      return (n < DIV_MIN) ? DIV_MIN : n;
   endfunction
endpackage

// File: rtl/clk_div_negreg.sv
// clk_div_negreg: negedge retiming flop for the odd-divisor half-cycle phase
`timescale 1ns/1ps
module clk_div_negreg (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   always_ff @(negedge i_clk) o_q <= i_rst ? 1'b0 : i_d;
endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable 50% duty integer clock divider with period tick
`timescale 1ns/1ps
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_div,
   input  logic             i_div_load,
   output logic             o_clk,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_div
);
   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   logic [CNT_W-1:0] r_pend, r_div, r_cnt, cnt_nx, n_eff, n_cl;
   logic [CNT_W:0]   h;
   logic             r_clk_p, r_clk_n, r_odd, r_tick, wrap;
   // phase is computed from the divisor that will govern the next count
   always_comb begin
      wrap   = r_cnt == r_div - ONE;
      cnt_nx = wrap ? '0 : r_cnt + ONE;
      n_eff  = wrap ? r_pend : r_div;
      h      = (CNT_W+1)'(half_hi(32'(n_eff)));
      n_cl   = CNT_W'(clamp_div(32'(i_div)));
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend  <= DEF;
         r_div   <= DEF;
         r_odd   <= DEF[0];
         r_cnt   <= DEF - ONE;
         r_clk_p <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         if (i_div_load) r_pend <= n_cl;
         if (!i_en) begin
            r_div   <= r_pend;
            r_odd   <= r_pend[0];
            r_cnt   <= r_pend - ONE;
            r_clk_p <= 1'b0;
            r_tick  <= 1'b0;
         end else begin
            if (wrap) begin
               r_div <= r_pend;
               r_odd <= r_pend[0];
            end
            r_cnt   <= cnt_nx;
            r_clk_p <= {1'b0, cnt_nx} < h;
            r_tick  <= cnt_nx == '0;
         end
      end
   end
   clk_div_negreg u_negreg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (r_clk_p),
      .o_q   (r_clk_n)
   );
   assign o_clk  = r_odd ? (r_clk_p & r_clk_n) : r_clk_p;
   assign o_tick = r_tick;
   assign o_div  = r_div;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed checks of divider periods, duty, load timing, disable and reset
`timescale 1ns/1ps
module tb_clk_div_gen;
   localparam int W = 16;
   logic         i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b1, i_div_load = 1'b0;
   logic [W-1:0] i_div = '0;
   logic [W-1:0] o_div;
   logic         o_clk, o_tick;
   int           n_tests = 0, n_fail = 0, p;
   time          t_rise = 0, t_fall = 0, min_hi = 1000;

   clk_div_gen #(.CNT_W(W), .DEF_DIV(4)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_div      (i_div),
      .i_div_load (i_div_load),
      .o_clk      (o_clk),
      .o_tick     (o_tick),
      .o_div      (o_div)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge o_clk) t_rise = $time;
   always @(negedge o_clk) begin
      t_fall = $time;
      if (t_fall - t_rise < min_hi) min_hi = t_fall - t_rise;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // cycles until the next tick, bounded
   task automatic period(output int c);
      c = 0;
      do begin
         step();
         c++;
      end while (!o_tick && c < 40);
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b11001100;
      step(2);
      chk("rst_clk", 32'(o_clk), 0);
      chk("rst_tick", 32'(o_tick), 0);
      chk("rst_div", 32'(o_div), 4);
      i_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("pat_clk", 32'(o_clk), 32'(pat[7-i]));
         chk("pat_tick", 32'(o_tick), 32'(i % 4 == 0));
      end
      chk("pat_div", 32'(o_div), 4);

      min_hi = 1000;
      step();
      chk("l7_tick0", 32'(o_tick), 1);
      step();
      i_div = 16'd7; i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      chk("l7_div_hold", 32'(o_div), 4);
      period(p);
      chk("l7_first", 32'(2 + p), 4);
      chk("l7_div", 32'(o_div), 7);
      chk("l7_clk_wrap", 32'(o_clk), 0);
      period(p);
      chk("l7_period", 32'(p), 7);
      chk("l7_hi", 32'(t_fall - t_rise), 35);
      chk("l7_min_hi", 32'(min_hi >= 20), 1);

      i_div = 16'd5; i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      period(p);
      chk("l5_tail", 32'(p), 6);
      chk("l5_div", 32'(o_div), 5);
      period(p);
      chk("l5_period", 32'(p), 5);
      chk("l5_hi", 32'(t_fall - t_rise), 25);

      step(4);
      i_div = 16'd3; i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      chk("lw_tick", 32'(o_tick), 1);
      chk("lw_div_hold", 32'(o_div), 5);
      period(p);
      chk("lw_period5", 32'(p), 5);
      chk("lw_div", 32'(o_div), 3);
      period(p);
      chk("l3_period", 32'(p), 3);
      chk("l3_hi", 32'(t_fall - t_rise), 15);

      i_div = 16'd0; i_div_load = 1'b1;
      step();
      i_div = 16'd1;
      step();
      i_div_load = 1'b0;
      period(p);
      chk("c_tail", 32'(p), 1);
      chk("c_div", 32'(o_div), 2);
      chk("c_clk0", 32'(o_clk), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("c_clk", 32'(o_clk), 32'(i % 2));
         chk("c_tick", 32'(o_tick), 32'(i % 2));
      end

      i_div = 16'd8; i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      period(p);
      chk("d8_tail", 32'(p), 1);
      chk("d8_div", 32'(o_div), 8);
      chk("d8_clk0", 32'(o_clk), 1);
      step();
      chk("d8_clk1", 32'(o_clk), 1);
      i_en = 1'b0;
      step();
      chk("dis_clk", 32'(o_clk), 0);
      chk("dis_tick", 32'(o_tick), 0);
      i_div = 16'd6; i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      step();
      chk("dis_div", 32'(o_div), 6);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("dis_idle_clk", 32'(o_clk), 0);
         chk("dis_idle_tick", 32'(o_tick), 0);
      end
      i_en = 1'b1;
      step();
      chk("en_tick", 32'(o_tick), 1);
      chk("en_clk", 32'(o_clk), 1);
      period(p);
      chk("en_period", 32'(p), 6);

      i_div = 16'd9; i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      period(p);
      chk("r9_tail", 32'(p), 5);
      chk("r9_div", 32'(o_div), 9);
      step(3);
      i_rst = 1'b1;
      step();
      chk("mrst_clk", 32'(o_clk), 0);
      chk("mrst_tick", 32'(o_tick), 0);
      chk("mrst_div", 32'(o_div), 4);
      i_rst = 1'b0;
      step();
      chk("mrst_tick1", 32'(o_tick), 1);
      chk("mrst_clk1", 32'(o_clk), 1);
      period(p);
      chk("mrst_period", 32'(p), 4);
      chk("mrst_div2", 32'(o_div), 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
